// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS IF stage.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam logic [2:0]  NPC_SEQ       = 3'b000;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and memory.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load wins over bubble, otherwise hold; reset loads the bubble value.
module if_id_reg #(
    parameter int          W      = 97,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_bubble,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Pipeline register with priority load > bubble > hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= BUBBLE;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_bubble) begin
            r_q <= BUBBLE;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage with IF/ID register; optional misaligned-fetch trap under FETCH_ADEL_CHECK_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    npc_sel,
    input  logic [31:0]   next_pc,
    input  logic          stall_f,
    fetch_stage_if.master imem,
    output logic [31:0]   instr_d,
    output logic [31:0]   pc_d,
    output logic [31:0]   pc4_d,
    output logic          valid_d
`ifdef FETCH_ADEL_CHECK_EN
    ,
    output logic          exc_adel_d
`endif
);

`ifdef FETCH_ADEL_CHECK_EN
    localparam int W = 98;
    localparam logic [W-1:0] BUBBLE = {1'b0, 1'b0, NOP_INSTR, 32'h0000_0000, 32'h0000_0000};
`else
    localparam int W = 97;
    localparam logic [W-1:0] BUBBLE = {1'b0, NOP_INSTR, 32'h0000_0000, 32'h0000_0000};
`endif

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_pend, w_pend_nxt;
    logic [31:0]  r_pend_tgt, w_tgt_nxt;
    logic [31:0]  r_buf, w_buf_nxt;
    logic         w_adel, w_advance, w_bubble, w_req, w_redirect;
    logic [31:0]  w_word;
    logic [W-1:0] w_ifid_d, w_ifid_q;

`ifdef FETCH_ADEL_CHECK_EN
    assign w_adel = (r_state == FETCH) && (r_pc[1:0] != 2'b00);
`else
    assign w_adel = 1'b0;
`endif

    assign w_redirect = (npc_sel != NPC_SEQ);

    // Next-state, next-PC and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_tgt_nxt   = r_pend_tgt;
        w_buf_nxt   = r_buf;
        w_advance   = 1'b0;
        w_bubble    = 1'b0;
        w_req       = 1'b0;
        w_word      = NOP_INSTR;
        case (r_state)
            FETCH: begin
                w_req  = ~w_adel;
                w_word = w_adel ? NOP_INSTR : imem.imem_rdata;
                if (stall_f) begin
                    // Park a completed word so memory is not asked twice
                    if (imem.imem_ready && !w_adel) begin
                        w_buf_nxt   = imem.imem_rdata;
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = FETCH;
                    end
                end else if (imem.imem_ready || w_adel) begin
                    w_advance = 1'b1;
                end else begin
                    w_bubble = 1'b1;
                    if (w_redirect) begin
                        w_pend_nxt = 1'b1;
                        w_tgt_nxt  = next_pc;
                    end else begin
                        w_pend_nxt = r_pend;
                    end
                end
            end
            HOLD: begin
                w_word = r_buf;
                if (!stall_f) begin
                    w_advance = 1'b1;
                end else begin
                    w_advance = 1'b0;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
        if (w_advance) begin
            w_state_nxt = FETCH;
            w_pend_nxt  = 1'b0;
            if (w_redirect) begin
                w_pc_nxt = next_pc;
            end else if (r_pend) begin
                w_pc_nxt = r_pend_tgt;
            end else begin
                w_pc_nxt = pc_plus4(r_pc);
            end
        end else begin
            w_pc_nxt = r_pc;
        end
    end

    // Fetch-side state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_pend     <= 1'b0;
            r_pend_tgt <= 32'h0000_0000;
            r_buf      <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_tgt <= w_tgt_nxt;
            r_buf      <= w_buf_nxt;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

`ifdef FETCH_ADEL_CHECK_EN
    assign w_ifid_d = {w_adel, 1'b1, w_word, r_pc, pc_plus4(r_pc)};
`else
    assign w_ifid_d = {1'b1, w_word, r_pc, pc_plus4(r_pc)};
`endif

    if_id_reg #(
        .W      (W),
        .BUBBLE (BUBBLE)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_advance),
        .i_bubble (w_bubble),
        .i_d      (w_ifid_d),
        .o_q      (w_ifid_q)
    );

    assign valid_d = w_ifid_q[96];
    assign instr_d = w_ifid_q[95:64];
    assign pc_d    = w_ifid_q[63:32];
    assign pc4_d   = w_ifid_q[31:0];
`ifdef FETCH_ADEL_CHECK_EN
    assign exc_adel_d = w_ifid_q[97];
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes expected results per cycle.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] addr;
        logic        req;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        exc;
    } obs_t;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f;
    logic [2:0]  npc_sel;
    logic [31:0] next_pc;
    logic [31:0] instr_d, pc_d, pc4_d;
    logic        valid_d;
    logic        exc_obs;

    fetch_stage_if imem();

`ifdef FETCH_ADEL_CHECK_EN
    logic exc_adel_d;
    assign exc_obs = exc_adel_d;
`else
    assign exc_obs = 1'b0;
`endif

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .npc_sel    (npc_sel),
        .next_pc    (next_pc),
        .stall_f    (stall_f),
        .imem       (imem),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc4_d      (pc4_d),
        .valid_d    (valid_d)
`ifdef FETCH_ADEL_CHECK_EN
        ,
        .exc_adel_d (exc_adel_d)
`endif
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_checks = 0;
    obs_t sb_q[$];
    obs_t obs;
    obs_t e;
    obs_t rst_exp;

    // Reference model state
    logic [31:0] m_pc, m_tgt, m_buf;
    logic        m_hold, m_pend;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        m_pc   = RST_PC;
        m_tgt  = 32'h0;
        m_buf  = 32'h0;
        m_hold = 1'b0;
        m_pend = 1'b0;
    endtask

    // One clock: drive, record pre-edge fetch side and post-edge IF/ID, push the model's expectation
    task automatic step(input logic st, input logic rdy, input logic [2:0] sel, input logic [31:0] npc);
        obs_t        x;
        logic        adel, adv;
        logic [31:0] word;
        stall_f = st;
        imem.imem_ready = rdy;
        npc_sel = sel;
        next_pc = npc;
        imem.imem_rdata = mem_word(imem.imem_addr);
        @(negedge clk);
        obs.addr = imem.imem_addr;
        obs.req  = imem.imem_req;
`ifdef FETCH_ADEL_CHECK_EN
        adel = !m_hold && (m_pc[1:0] != 2'b00);
`else
        adel = 1'b0;
`endif
        x.addr = m_pc;
        x.req  = !m_hold && !adel;
        adv  = !st && (m_hold || rdy || adel);
        word = adel ? NOP : (m_hold ? m_buf : mem_word(m_pc));
        if (adv) begin
            x.instr = word; x.pc = m_pc; x.pc4 = m_pc + 32'd4; x.valid = 1'b1; x.exc = adel;
            m_pc   = (sel != 3'b000) ? npc : (m_pend ? m_tgt : m_pc + 32'd4);
            m_pend = 1'b0;
            m_hold = 1'b0;
        end else if (!st) begin
            x.instr = NOP; x.pc = 32'h0; x.pc4 = 32'h0; x.valid = 1'b0; x.exc = 1'b0;
            if (sel != 3'b000) begin
                m_pend = 1'b1;
                m_tgt  = npc;
            end
        end else begin
            x.instr = instr_d; x.pc = e.pc; x.pc4 = e.pc4; x.valid = e.valid; x.exc = e.exc;
            x.instr = e.instr;
            if (!m_hold && rdy && !adel) begin
                m_buf  = word;
                m_hold = 1'b1;
            end
        end
        sb_q.push_back(x);
        e = x;
        @(posedge clk);
        #1;
        obs.instr = instr_d;
        obs.pc    = pc_d;
        obs.pc4   = pc4_d;
        obs.valid = valid_d;
        obs.exc   = exc_obs;
    endtask

    task automatic test_reset();
        obs = '{addr: imem.imem_addr, req: imem.imem_req, instr: instr_d, pc: pc_d,
                pc4: pc4_d, valid: valid_d, exc: exc_obs};
        n_checks++;
        if (obs !== rst_exp) $display("FAIL reset_state got %h exp %h", obs, rst_exp);
        else n_pass++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        obs_t x;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 3'b000, 32'h0);
            x = sb_q.pop_front();
            n_checks++;
            if (obs !== x) $display("FAIL seq[%0d] got %h exp %h", i, obs, x);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        obs_t x;
        // Redirect presented while 3008 is in IF; 3008 is the delay slot
        step(1'b0, 1'b1, 3'b010, 32'h0000_3100);
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x || pc_d !== 32'h0000_3008) $display("FAIL redirect_slot got %h exp %h", obs, x);
        else n_pass++;
        step(1'b0, 1'b1, 3'b000, 32'h0);
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x || obs.addr !== 32'h0000_3100) $display("FAIL redirect_target got %h exp %h", obs, x);
        else n_pass++;
    endtask

    task automatic test_bubble();
        obs_t x;
        logic        rdy [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  sel [4] = '{3'b001, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, rdy[i], sel[i], 32'h0000_3200);
            x = sb_q.pop_front();
            n_checks++;
            if (obs !== x) $display("FAIL bubble[%0d] got %h exp %h", i, obs, x);
            else n_pass++;
        end
        n_checks++;
        if (imem.imem_addr !== 32'h0000_3204) $display("FAIL bubble_pend_pc got %h exp %h", imem.imem_addr, 32'h0000_3204);
        else n_pass++;
    endtask

    task automatic test_stall();
        obs_t x;
        logic st  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(st[i], rdy[i], 3'b000, 32'h0);
            x = sb_q.pop_front();
            n_checks++;
            if (obs !== x) $display("FAIL stall[%0d] got %h exp %h", i, obs, x);
            else n_pass++;
        end
    endtask

    task automatic test_pend_override();
        obs_t x;
        logic       rdy [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0] sel [3] = '{3'b001, 3'b010, 3'b000};
        logic [31:0] tg [3] = '{32'h0000_3400, 32'h0000_3500, 32'h0};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, rdy[i], sel[i], tg[i]);
            x = sb_q.pop_front();
            n_checks++;
            if (obs !== x) $display("FAIL pend_override[%0d] got %h exp %h", i, obs, x);
            else n_pass++;
        end
        n_checks++;
        if (imem.imem_addr !== 32'h0000_3504) $display("FAIL pend_override_pc got %h exp %h", imem.imem_addr, 32'h0000_3504);
        else n_pass++;
    endtask

    task automatic test_wrap();
        obs_t x;
        logic [2:0]  sel [3] = '{3'b100, 3'b000, 3'b000};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, sel[i], 32'hFFFF_FFFC);
            x = sb_q.pop_front();
            n_checks++;
            if (obs !== x) $display("FAIL wrap[%0d] got %h exp %h", i, obs, x);
            else n_pass++;
        end
        n_checks++;
        if (pc_d !== 32'h0 || pc4_d !== 32'h4) $display("FAIL wrap_zero got %h/%h exp 0/4", pc_d, pc4_d);
        else n_pass++;
    endtask

`ifdef FETCH_ADEL_CHECK_EN
    task automatic test_adel();
        obs_t x;
        logic [2:0]  sel [3] = '{3'b011, 3'b001, 3'b000};
        logic [31:0] tg  [3] = '{32'h0000_3102, 32'h0000_3000, 32'h0};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, sel[i], tg[i]);
            x = sb_q.pop_front();
            n_checks++;
            if (obs !== x) $display("FAIL adel[%0d] got %h exp %h", i, obs, x);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (exc_adel_d !== 1'b1 || pc_d !== 32'h0000_3102 || obs.req !== 1'b0)
                    $display("FAIL adel_trap got exc=%b pc=%h req=%b exp 1/3102/0", exc_adel_d, pc_d, obs.req);
                else n_pass++;
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        obs_t x;
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                 32'h0000_4000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00});
            x = sb_q.pop_front();
            n_checks++;
            if (obs !== x) $display("FAIL random[%0d] got %h exp %h", i, obs, x);
            else n_pass++;
        end
    endtask

    task automatic test_reset_hold();
        obs_t x;
        step(1'b1, 1'b1, 3'b000, 32'h0);
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x) $display("FAIL hold_entry got %h exp %h", obs, x);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        obs = '{addr: imem.imem_addr, req: imem.imem_req, instr: instr_d, pc: pc_d,
                pc4: pc4_d, valid: valid_d, exc: exc_obs};
        n_checks++;
        if (obs !== rst_exp) $display("FAIL async_reset got %h exp %h", obs, rst_exp);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(1'b0, 1'b1, 3'b000, 32'h0);
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x || obs.addr !== RST_PC) $display("FAIL after_reset got %h exp %h", obs, x);
        else n_pass++;
    endtask

    initial begin
        rst_exp = '{addr: RST_PC, req: 1'b1, instr: NOP, pc: 32'h0, pc4: 32'h0, valid: 1'b0, exc: 1'b0};
        e = rst_exp;
        reset = 1'b1;
        stall_f = 1'b0;
        npc_sel = 3'b000;
        next_pc = 32'h0;
        imem.imem_ready = 1'b0;
        imem.imem_rdata = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_redirect();
        test_bubble();
        test_stall();
        test_pend_override();
        test_wrap();
`ifdef FETCH_ADEL_CHECK_EN
        test_adel();
`endif
        test_back_to_back();
        test_reset_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
